// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port between N_REQ valid/ready producers.
// Bursts of up to MAX_BURST beats per grant; every push is gated by the FIFO full flag.
module fifo_push_arbiter #(
  parameter int WIDTH_DATA = 8,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*WIDTH_DATA-1:0] i_req_data,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic                        i_fifo_full,
  output logic                        o_fifo_push,
  output logic [WIDTH_DATA-1:0]       o_fifo_data,
  output logic [$clog2(N_REQ)-1:0]    o_grant_id,
  output logic                        o_busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] PTR_RST   = IDW'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q;
  logic [IDW-1:0]  owner_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [CW-1:0]   burst_q;
  logic [CW-1:0]   burst_d;
  logic [IDW-1:0]  winner;
  logic            found;
  logic            beat;
  logic            rel_now;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % N_REQ;
    return sum[IDW-1:0];
  endfunction

  // Scan downward so the nearest requester after the pointer wins; the pointer itself is last.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    for (int i = N_REQ; i >= 1; i--) begin
      if (i_req_valid[rr_idx(rr_ptr_q, i)]) begin
        found  = 1'b1;
        winner = rr_idx(rr_ptr_q, i);
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (state_q == GRANT) begin
      o_req_ready[owner_q] = ~i_fifo_full;
    end
  end

  assign beat        = i_req_valid[owner_q] & o_req_ready[owner_q];
  assign o_fifo_push = beat;
  assign o_busy      = (state_q == GRANT);
  assign o_grant_id  = owner_q;
  assign o_fifo_data = o_busy ? i_req_data[owner_q*WIDTH_DATA +: WIDTH_DATA] : '0;
  assign burst_d     = beat ? burst_q + CW'(1) : burst_q;
  // Full never releases the grant; only burst exhaustion or the owner going idle does.
  assign rel_now     = (state_q == GRANT) &&
                       ((beat && (burst_q == LAST_BEAT)) || !i_req_valid[owner_q]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= PTR_RST;
      burst_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q  <= GRANT;
            owner_q  <= winner;
            rr_ptr_q <= winner;
            burst_q  <= '0;
          end
        end
        GRANT: begin
          if (rel_now) begin
            burst_q <= '0;
            if (found) begin
              owner_q  <= winner;
              rr_ptr_q <= winner;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            burst_q <= burst_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: cycle table for the FSM plus scoreboarded producer streams.
module tb_fifo_push_arbiter;
  localparam int W     = 8;
  localparam int N     = 4;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   valid;
  logic [N*W-1:0] data;
  logic [N-1:0]   ready;
  logic           full;
  logic           push;
  logic [W-1:0]   fdata;
  logic [1:0]     gid;
  logic           busy;

  always #5 clk = ~clk;

  fifo_push_arbiter #(.WIDTH_DATA(W), .N_REQ(N), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(ready), .i_fifo_full(full), .o_fifo_push(push),
    .o_fifo_data(fdata), .o_grant_id(gid), .o_busy(busy)
  );

  typedef struct {
    logic [N-1:0] valid;
    logic         full;
    logic [N-1:0] ready;
    logic         push;
    logic [1:0]   gid;
    logic         busy;
  } vec_t;

  vec_t         tbl[12];
  logic [W-1:0] src_q[N][$];
  logic [W-1:0] exp_q[N][$];
  int           n_pass = 0;
  int           n_chk  = 0;
  int           cyc;
  int           n_push;
  int           fifo_cnt;
  int           base_push;
  bit           use_fifo;
  bit           pop;
  logic         log_push[64];
  logic [1:0]   log_gid[64];
  logic         log_busy[64];
  logic [N-1:0] log_ready[64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; data = '0; full = 1'b0; pop = 1'b0;
    use_fifo = 1'b0; fifo_cnt = 0; n_push = 0;
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic load(input int k, input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      src_q[k].push_back(base + W'(i));
      exp_q[k].push_back(base + W'(i));
    end
  endtask

  // One clock: producers present queue heads, outputs sampled at the falling edge.
  task automatic cycle();
    for (int k = 0; k < N; k++) begin
      valid[k] = (src_q[k].size() > 0);
      data[k*W +: W] = valid[k] ? src_q[k][0] : '0;
    end
    if (use_fifo) full = (fifo_cnt >= DEPTH);
    @(negedge clk);
    if (cyc < 64) begin
      log_push[cyc] = push; log_gid[cyc] = gid; log_busy[cyc] = busy; log_ready[cyc] = ready;
    end
    chk("ready_onehot0", 32'($onehot0(ready)), 32'(1));
    chk("push_eq_handshake", 32'(push), 32'(|(ready & valid)));
    if (full) chk("push_while_full", 32'(push), 32'(0));
    if (push) begin
      n_push++;
      if (exp_q[gid].size() == 0) chk("push_without_word", 32'(push), 32'(0));
      else chk("push_data_order", 32'(fdata), 32'(exp_q[gid].pop_front()));
    end
    for (int k = 0; k < N; k++) begin
      if (valid[k] && ready[k]) void'(src_q[k].pop_front());
    end
    if (use_fifo) begin
      if (pop && fifo_cnt > 0) fifo_cnt--;
      if (push) fifo_cnt++;
      chk("fifo_no_overflow", 32'(fifo_cnt <= DEPTH), 32'(1));
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[3]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1};
    tbl[4]  = '{4'b0110, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[5]  = '{4'b0010, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1};
    tbl[6]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[7]  = '{4'b0000, 1'b0, 4'b0010, 1'b0, 2'd1, 1'b1};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
    tbl[9]  = '{4'b1001, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0};
    tbl[10] = '{4'b1001, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1};
    tbl[11] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1};

    // reset state
    rst_n = 1'b0; valid = '0; data = '0; full = 1'b0; pop = 1'b0; use_fifo = 1'b0;
    #12;
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_push", 32'(push), 32'(0));
    chk("rst_data", 32'(fdata), 32'(0));
    chk("rst_gid", 32'(gid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));

    // cycle table: grant, full hold, valid drop, idle, RR pointer kept across IDLE
    do_reset();
    data = {8'h43, 8'h42, 8'h41, 8'h40};
    for (int i = 0; i < 12; i++) begin
      valid = tbl[i].valid;
      full  = tbl[i].full;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_push", i), 32'(push), 32'(tbl[i].push));
      chk($sformatf("tbl%0d_gid", i), 32'(gid), 32'(tbl[i].gid));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_data", i), 32'(fdata),
          tbl[i].busy ? 32'(8'h40 + 8'(tbl[i].gid)) : 32'(0));
      @(posedge clk); #1;
    end

    // single producer 2, six words, burst rollover re-grants with no gap
    do_reset();
    load(2, 8'h10, 6);
    for (int c = 0; c < 8; c++) cycle();
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("single_push_c%0d", c), 32'(log_push[c]), 32'(c >= 1 && c <= 6));
      if (c >= 1 && c <= 6) chk($sformatf("single_gid_c%0d", c), 32'(log_gid[c]), 32'(2));
    end
    chk("single_all_consumed", 32'(exp_q[2].size()), 32'(0));

    // four streaming producers: 0,1,2,3,0 with four beats each
    do_reset();
    for (int k = 0; k < N; k++) load(k, 8'(8'h80 + 8'(16 * k)), 6);
    for (int c = 0; c < 18; c++) cycle();
    for (int c = 1; c < 18; c++) begin
      chk($sformatf("rr_gid_c%0d", c), 32'(log_gid[c]), 32'(((c - 1) / MB) % N));
      chk($sformatf("rr_push_c%0d", c), 32'(log_push[c]), 32'(1));
      chk($sformatf("rr_busy_c%0d", c), 32'(log_busy[c]), 32'(1));
    end

    // owner 1 stalled by full for 3 cycles after 2 beats, then 2 beats and rotation to 3
    do_reset();
    load(1, 8'h20, 6);
    load(3, 8'h60, 4);
    for (int c = 0; c < 9; c++) begin
      full = (c >= 3 && c <= 5);
      cycle();
    end
    for (int c = 1; c < 9; c++) begin
      chk($sformatf("full_push_c%0d", c), 32'(log_push[c]), 32'(!(c >= 3 && c <= 5)));
      chk($sformatf("full_gid_c%0d", c), 32'(log_gid[c]), 32'(c == 8 ? 3 : 1));
    end
    for (int c = 3; c <= 5; c++) chk($sformatf("full_ready_c%0d", c), 32'(log_ready[c]), 32'(0));

    // owner 0 drops valid after 2 beats; 1 and 2 idle, 3 takes over next cycle
    do_reset();
    full = 1'b0;
    load(0, 8'h50, 2);
    load(3, 8'h70, 3);
    for (int c = 0; c < 5; c++) cycle();
    chk("drop_push_c2", 32'(log_push[2]), 32'(1));
    chk("drop_push_c3", 32'(log_push[3]), 32'(0));
    chk("drop_gid_c3", 32'(log_gid[3]), 32'(0));
    chk("drop_ready_c3", 32'(log_ready[3]), 32'(4'b0001));
    chk("drop_gid_c4", 32'(log_gid[4]), 32'(3));
    chk("drop_push_c4", 32'(log_push[4]), 32'(1));

    // reset pulse mid-burst (owner 2, one beat done)
    do_reset();
    load(2, 8'h30, 4);
    cycle();
    cycle();
    chk("midrst_pre_gid", 32'(gid), 32'(2));
    chk("midrst_pre_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'(0));
    chk("midrst_push", 32'(push), 32'(0));
    chk("midrst_data", 32'(fdata), 32'(0));
    chk("midrst_gid", 32'(gid), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    do_reset();
    load(0, 8'h90, 2);
    load(2, 8'hA0, 2);
    cycle();
    cycle();
    chk("postrst_push_c0", 32'(log_push[0]), 32'(0));
    chk("postrst_gid_c1", 32'(log_gid[1]), 32'(0));
    chk("postrst_push_c1", 32'(log_push[1]), 32'(1));

    // integrated with a 16-deep FIFO model, no pops: exactly 16 pushes, then one per pop
    do_reset();
    use_fifo = 1'b1;
    for (int k = 0; k < N; k++) load(k, 8'(8'hC0 + 8'(8 * k)), 8);
    for (int c = 0; c < 22; c++) cycle();
    chk("fifo_fill_pushes", 32'(n_push), 32'(DEPTH));
    chk("fifo_fill_level", 32'(fifo_cnt), 32'(DEPTH));
    for (int p = 0; p < 3; p++) begin
      base_push = n_push;
      pop = 1'b1;
      cycle();
      pop = 1'b0;
      cycle(); cycle(); cycle();
      chk($sformatf("fifo_pop%0d_pushes", p), 32'(n_push - base_push), 32'(1));
    end
    chk("fifo_final_level", 32'(fifo_cnt), 32'(DEPTH));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
